// File: rtl/dot_product_sequencer.sv
// Job sequencer for a single MAC unit: clears the accumulator, streams operand pairs,
// waits for the final sum and returns it over a valid/ready result port.
module dot_product_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_c,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic [DATA_WIDTH-1:0] mac_c,
    output logic                  mac_clear,
    output logic                  mac_output_signal,
    input  logic [ACC_WIDTH-1:0]  mac_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUT
    } state_t;

    state_t                state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0] mac_b_q;
    logic [DATA_WIDTH-1:0] mac_c_q;
    logic                  mac_clear_q;
    logic                  out_valid_q;
    logic [ACC_WIDTH-1:0]  out_data_q;

    // The MAC adds every clock, so operands default to zero unless a beat lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            mac_clear_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            mac_clear_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q       <= vec_len;
                        count_q     <= '0;
                        mac_clear_q <= 1'b1;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    state_q <= (len_q != '0) ? FEED : DRAIN;
                end
                FEED: begin
                    if (in_valid) begin
                        mac_b_q <= in_b;
                        mac_c_q <= in_c;
                        count_q <= count_q + LEN_WIDTH'(1);
                        if (count_q == len_q - LEN_WIDTH'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    out_data_q  <= mac_result;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready          = (state_q == FEED);
    assign busy              = (state_q != IDLE);
    assign mac_output_signal = (state_q == DRAIN);
    assign mac_b             = mac_b_q;
    assign mac_c             = mac_c_q;
    assign mac_clear         = mac_clear_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Randomized bench for dot_product_sequencer with an attached MAC model
// and a sum/latency reference computed from the job description.
module tb_dot_product_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  vec_len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_b;
    logic [7:0]  in_c;
    logic [7:0]  mac_b;
    logic [7:0]  mac_c;
    logic        mac_clear;
    logic        mac_output_signal;
    logic [15:0] mac_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] bv[256];
    logic [7:0] cv[256];

    dot_product_sequencer #(
        .DATA_WIDTH(8),
        .ACC_WIDTH (16),
        .LEN_WIDTH (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .vec_len          (vec_len),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_b             (in_b),
        .in_c             (in_c),
        .mac_b            (mac_b),
        .mac_c            (mac_c),
        .mac_clear        (mac_clear),
        .mac_output_signal(mac_output_signal),
        .mac_result       (mac_result),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // MAC model: accumulates every clock, result visible combinationally.
    logic [15:0] acc_q;
    assign mac_result = acc_q + 16'(16'(mac_b) * 16'(mac_c));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else if (mac_clear) acc_q <= '0;
        else acc_q <= mac_result;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_job(input int n, input int gaps, input int hold);
        int          s;
        int          r;
        int          g_total;
        int          gap_at[256];
        logic [31:0] sum;
        logic [15:0] exp_data;
        sum = 0;
        for (int i = 0; i < 256; i++) gap_at[i] = 0;
        for (int i = 0; i < n; i++) sum += 32'(bv[i]) * 32'(cv[i]);
        exp_data = sum[15:0];
        g_total = (n > 0) ? gaps : 0;
        if (n > 0)
            for (int g = 0; g < gaps; g++) gap_at[$urandom_range(0, n - 1)]++;
        out_ready = (hold == 0);
        @(negedge clk);
        start   = 1'b1;
        vec_len = 8'(n);
        @(negedge clk);
        s     = cyc;
        start = 1'b0;
        check("mac_clear_on", 32'(mac_clear), 1);
        check("busy_clear", 32'(busy), 1);
        in_valid = 1'b1;
        in_b     = 8'hFF;
        in_c     = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        check("mac_clear_off", 32'(mac_clear), 0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap_at[i]; g++) begin
                check("in_ready_gap", 32'(in_ready), 1);
                in_valid = 1'b0;
                in_b     = 8'($urandom);
                in_c     = 8'($urandom);
                @(negedge clk);
                check("gap_mac_b", 32'(mac_b), 0);
                check("gap_mac_c", 32'(mac_c), 0);
            end
            check("in_ready_beat", 32'(in_ready), 1);
            in_valid = 1'b1;
            in_b     = bv[i];
            in_c     = cv[i];
            @(negedge clk);
            check("beat_mac_b", 32'(mac_b), 32'(bv[i]));
            check("beat_mac_c", 32'(mac_c), 32'(cv[i]));
        end
        in_valid = 1'b0;
        check("drain_signal", 32'(mac_output_signal), 1);
        check("drain_in_ready", 32'(in_ready), 0);
        r = 0;
        while (!out_valid && r < 40) begin
            @(negedge clk);
            r++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            out_ready = 1'b1;
            return;
        end
        check("latency", 32'(cyc), 32'(s + 2 + n + g_total));
        check("out_data", 32'(out_data), 32'(exp_data));
        for (int k = 0; k < hold; k++) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(exp_data));
            start = (k == 2);
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (hold > 0) @(negedge clk);
        else @(negedge clk);
        check("valid_dropped", 32'(out_valid), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        in_b      = '0;
        in_c      = '0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mac_clear", 32'(mac_clear), 0);
        check("rst_out_data", 32'(out_data), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_mac_b", 32'(mac_b), 0);
        check("idle_drain", 32'(mac_output_signal), 0);

        bv[0] = 8'd1; bv[1] = 8'd2; bv[2] = 8'd3; bv[3] = 8'd4;
        cv[0] = 8'd5; cv[1] = 8'd6; cv[2] = 8'd7; cv[3] = 8'd8;
        run_job(4, 0, 0);
        run_job(4, 3, 0);

        bv[0] = 8'd255; bv[1] = 8'd255;
        cv[0] = 8'd255; cv[1] = 8'd255;
        run_job(2, 0, 5);

        bv[0] = 8'd3;
        cv[0] = 8'd3;
        run_job(1, 0, 0);

        // Abandon a job mid-stream with an asynchronous reset.
        @(negedge clk);
        start   = 1'b1;
        vec_len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_b     = 8'd7;
        in_c     = 8'd9;
        @(negedge clk);
        in_b = 8'd2;
        in_c = 8'd6;
        @(negedge clk);
        check("pre_rst_mac_b", 32'(mac_b), 2);
        #2 reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 0);
        check("async_in_ready", 32'(in_ready), 0);
        check("async_mac_b", 32'(mac_b), 0);
        check("async_mac_c", 32'(mac_c), 0);
        check("async_out_valid", 32'(out_valid), 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_partial", 32'(out_valid), 0);
        end
        run_job(0, 0, 0);

        for (int j = 0; j < 6; j++) begin
            int n;
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                bv[i] = 8'($urandom);
                cv[i] = 8'($urandom);
            end
            run_job(n, $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
